// File: rtl/pixel_unpacker.sv
// Merges one 32-bit word per colour channel into eight 12-bit RGB pixels,
// using two ping-pong banks so one word set can load while the other drains.
module pixel_unpacker (
    input  logic        clk,
    input  logic        rst_,
    input  logic        enable,
    input  logic        rb_rts_pb,
    input  logic [31:0] rb_data,
    output logic        pb_rtr_rb,
    input  logic        gb_rts_pb,
    input  logic [31:0] gb_data,
    output logic        pb_rtr_gb,
    input  logic        bb_rts_pb,
    input  logic [31:0] bb_data,
    output logic        pb_rtr_bb,
    output logic        pb_rts_cb,
    output logic [11:0] pb_data,
    input  logic        cb_rtr_pb
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned FLAG_W = 3;

    // Per-bank storage; loaded bits are {R, G, B}
    logic [1:0][WORD_W-1:0] r_word;
    logic [1:0][WORD_W-1:0] g_word;
    logic [1:0][WORD_W-1:0] b_word;
    logic [1:0][FLAG_W-1:0] loaded;
    logic [1:0][FLAG_W-1:0] loaded_nxt;

    logic             fill_ptr;
    logic             drain_ptr;
    logic [IDX_W-1:0] pix_idx;

    logic [FLAG_W-1:0] fill_flags;
    logic [FLAG_W-1:0] fill_flags_nxt;
    logic [FLAG_W-1:0] load_xfer;
    logic              fill_done;
    logic              out_xfer;
    logic              last_pix;
    logic [4:0]        nib_lsb;

    // Upstream handshakes: a channel is accepted while its slot in the fill bank is empty
    always_comb begin
        fill_flags     = loaded[fill_ptr];
        pb_rtr_rb      = enable & ~fill_flags[2];
        pb_rtr_gb      = enable & ~fill_flags[1];
        pb_rtr_bb      = enable & ~fill_flags[0];
        load_xfer      = {rb_rts_pb & pb_rtr_rb, gb_rts_pb & pb_rtr_gb, bb_rts_pb & pb_rtr_bb};
        fill_flags_nxt = fill_flags | load_xfer;
        fill_done      = (|load_xfer) && (fill_flags_nxt == 3'b111);
    end

    // Downstream side: pixel 0 lives in the top nibble of each word
    always_comb begin
        pb_rts_cb = enable & (&loaded[drain_ptr]);
        out_xfer  = pb_rts_cb & cb_rtr_pb;
        last_pix  = out_xfer && (pix_idx == 3'd7);
        nib_lsb   = {~pix_idx, 2'b00};
        pb_data   = {r_word[drain_ptr][nib_lsb +: NIB_W],
                     g_word[drain_ptr][nib_lsb +: NIB_W],
                     b_word[drain_ptr][nib_lsb +: NIB_W]};
    end

    // A full fill bank takes no loads, so clearing the drain bank last is safe when both pointers match
    always_comb begin
        loaded_nxt           = loaded;
        loaded_nxt[fill_ptr] = fill_flags_nxt;
        if (last_pix) begin
            loaded_nxt[drain_ptr] = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_word    <= '0;
            g_word    <= '0;
            b_word    <= '0;
            loaded    <= '0;
            fill_ptr  <= 1'b0;
            drain_ptr <= 1'b0;
            pix_idx   <= '0;
        end else begin
            loaded <= loaded_nxt;
            if (load_xfer[2]) r_word[fill_ptr] <= rb_data;
            if (load_xfer[1]) g_word[fill_ptr] <= gb_data;
            if (load_xfer[0]) b_word[fill_ptr] <= bb_data;
            if (fill_done) fill_ptr <= ~fill_ptr;
            if (out_xfer) pix_idx <= pix_idx + IDX_W'(1);
            if (last_pix) drain_ptr <= ~drain_ptr;
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: reset, single set, staggered loads,
// ping-pong streaming, back-pressure, enable hold and mid-bank reset.
module tb_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst_;
    logic        enable;
    logic        rb_rts_pb, gb_rts_pb, bb_rts_pb;
    logic [31:0] rb_data, gb_data, bb_data;
    logic        pb_rtr_rb, pb_rtr_gb, pb_rtr_bb;
    logic        pb_rts_cb;
    logic [11:0] pb_data;
    logic        cb_rtr_pb;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] r_set [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    logic [31:0] g_set [4] = '{32'hA5A5F00F, 32'h13579BDF, 32'h02468ACE, 32'hC0FFEE11};
    logic [31:0] b_set [4] = '{32'h0F1E2D3C, 32'hFFFF0000, 32'h00FF00FF, 32'h5A5A3C3C};

    always #5 clk = ~clk;

    pixel_unpacker dut (
        .clk(clk), .rst_(rst_), .enable(enable),
        .rb_rts_pb(rb_rts_pb), .rb_data(rb_data), .pb_rtr_rb(pb_rtr_rb),
        .gb_rts_pb(gb_rts_pb), .gb_data(gb_data), .pb_rtr_gb(pb_rtr_gb),
        .bb_rts_pb(bb_rts_pb), .bb_data(bb_data), .pb_rtr_bb(pb_rtr_bb),
        .pb_rts_cb(pb_rts_cb), .pb_data(pb_data), .cb_rtr_pb(cb_rtr_pb)
    );

    // Expected pixel i: nibble i counted from the top of each word
    function automatic logic [11:0] exp_pix(input logic [31:0] r, input logic [31:0] g,
                                            input logic [31:0] b, input int i);
        logic [31:0] rs, gs, bs;
        rs = r >> (28 - 4 * i);
        gs = g >> (28 - 4 * i);
        bs = b >> (28 - 4 * i);
        return {rs[3:0], gs[3:0], bs[3:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rb_rts_pb = 1'b0;
        gb_rts_pb = 1'b0;
        bb_rts_pb = 1'b0;
    endtask

    task automatic drive_set(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
        rb_data = r; gb_data = g; bb_data = b;
        rb_rts_pb = 1'b1; gb_rts_pb = 1'b1; bb_rts_pb = 1'b1;
    endtask

    task automatic test_reset;
        rst_ = 1'b0; enable = 1'b1; cb_rtr_pb = 1'b0;
        rb_data = '0; gb_data = '0; bb_data = '0;
        idle();
        #3;
        n_checks++;
        if (pb_rts_cb !== 1'b0) begin
            n_fails++; $display("FAIL reset_rts: got %b expected 0", pb_rts_cb);
        end
        n_checks++;
        if (pb_data !== 12'h000) begin
            n_fails++; $display("FAIL reset_data: got %h expected 000", pb_data);
        end
        n_checks++;
        if ({pb_rtr_rb, pb_rtr_gb, pb_rtr_bb} !== 3'b111) begin
            n_fails++; $display("FAIL reset_rtr: got %b expected 111", {pb_rtr_rb, pb_rtr_gb, pb_rtr_bb});
        end
        tick();
        rst_ = 1'b1;
        #1;
    endtask

    task automatic test_single_set;
        logic [11:0] exp_v [8];
        exp_v = '{12'hF08, 12'hE19, 12'hD2A, 12'hC3B, 12'hB4C, 12'hA5D, 12'h96E, 12'h87F};
        cb_rtr_pb = 1'b1;
        drive_set(32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF);
        #1;
        n_checks++;
        if ({pb_rtr_rb, pb_rtr_gb, pb_rtr_bb, pb_rts_cb} !== 4'b1110) begin
            n_fails++; $display("FAIL single_preload: rtr/rts got %b expected 1110",
                                {pb_rtr_rb, pb_rtr_gb, pb_rtr_bb, pb_rts_cb});
        end
        tick();
        idle();
        #1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({pb_rts_cb, pb_data} !== {1'b1, exp_v[i]}) begin
                n_fails++; $display("FAIL single_pix%0d: got rts=%b data=%h expected rts=1 data=%h",
                                    i, pb_rts_cb, pb_data, exp_v[i]);
            end
            tick();
        end
        n_checks++;
        if (pb_rts_cb !== 1'b0) begin
            n_fails++; $display("FAIL single_after: rts got %b expected 0", pb_rts_cb);
        end
    endtask

    task automatic test_staggered;
        logic [31:0] r, g, b;
        r = 32'h12345678; g = 32'h9ABCDEF0; b = 32'h0F1E2D3C;
        rb_data = r; gb_data = g; bb_data = b;
        cb_rtr_pb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rb_rts_pb = (c == 0);
            bb_rts_pb = (c == 3);
            gb_rts_pb = (c == 7);
            #1;
            n_checks++;
            if (pb_rts_cb !== 1'b0) begin
                n_fails++; $display("FAIL stagger_rts_c%0d: got %b expected 0", c, pb_rts_cb);
            end
            if (c >= 1) begin
                n_checks++;
                if (pb_rtr_rb !== 1'b0) begin
                    n_fails++; $display("FAIL stagger_rtr_rb_c%0d: got %b expected 0", c, pb_rtr_rb);
                end
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if ({pb_rts_cb, pb_rtr_rb, pb_data} !== {1'b1, 1'b1, 12'h190}) begin
            n_fails++; $display("FAIL stagger_c8: got rts=%b rtr_rb=%b data=%h expected rts=1 rtr_rb=1 data=190",
                                pb_rts_cb, pb_rtr_rb, pb_data);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({pb_rts_cb, pb_data} !== {1'b1, exp_pix(r, g, b, i)}) begin
                n_fails++; $display("FAIL stagger_pix%0d: got rts=%b data=%h expected rts=1 data=%h",
                                    i, pb_rts_cb, pb_data, exp_pix(r, g, b, i));
            end
            tick();
        end
        n_checks++;
        if (pb_rts_cb !== 1'b0) begin
            n_fails++; $display("FAIL stagger_after: rts got %b expected 0", pb_rts_cb);
        end
    endtask

    // Full-rate streaming: rtr is low exactly while both banks hold complete sets
    task automatic test_ping_pong;
        int  k;
        logic exp_rtr, exp_rts;
        logic [11:0] ep;
        k = 0;
        cb_rtr_pb = 1'b1;
        for (int c = 0; c < 34; c++) begin
            if (k < 4) drive_set(r_set[k], g_set[k], b_set[k]);
            else idle();
            #1;
            exp_rtr = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16) || (c >= 18 && c <= 24));
            exp_rts = (c >= 1 && c <= 32);
            n_checks++;
            if ({pb_rtr_rb, pb_rtr_gb, pb_rtr_bb} !== {3{exp_rtr}}) begin
                n_fails++; $display("FAIL pp_rtr_c%0d: got %b expected %b", c,
                                    {pb_rtr_rb, pb_rtr_gb, pb_rtr_bb}, {3{exp_rtr}});
            end
            n_checks++;
            if (pb_rts_cb !== exp_rts) begin
                n_fails++; $display("FAIL pp_rts_c%0d: got %b expected %b", c, pb_rts_cb, exp_rts);
            end
            if (exp_rts) begin
                ep = exp_pix(r_set[(c - 1) / 8], g_set[(c - 1) / 8], b_set[(c - 1) / 8], (c - 1) % 8);
                n_checks++;
                if (pb_data !== ep) begin
                    n_fails++; $display("FAIL pp_data_c%0d: got %h expected %h", c, pb_data, ep);
                end
            end
            if (k < 4 && pb_rtr_rb && pb_rtr_gb && pb_rtr_bb) k++;
            tick();
        end
        idle();
        n_checks++;
        if (k != 4) begin
            n_fails++; $display("FAIL pp_sets_loaded: got %0d expected 4", k);
        end
    endtask

    task automatic test_back_pressure;
        int idx, cyc;
        logic [11:0] ep;
        cb_rtr_pb = 1'b0;
        drive_set(r_set[2], g_set[2], b_set[2]);
        tick();
        idx = 0;
        cyc = 1;
        while (idx < 16 && cyc < 200) begin
            if (cyc == 1) drive_set(r_set[3], g_set[3], b_set[3]);
            else idle();
            cb_rtr_pb = 1'($urandom_range(0, 1));
            #1;
            ep = exp_pix(r_set[2 + idx / 8], g_set[2 + idx / 8], b_set[2 + idx / 8], idx % 8);
            n_checks++;
            if ({pb_rts_cb, pb_data} !== {1'b1, ep}) begin
                n_fails++; $display("FAIL bp_pix%0d_cyc%0d: got rts=%b data=%h expected rts=1 data=%h",
                                    idx, cyc, pb_rts_cb, pb_data, ep);
            end
            if (cb_rtr_pb) idx++;
            tick();
            cyc++;
        end
        idle();
        cb_rtr_pb = 1'b1;
        #1;
        n_checks++;
        if (idx != 16) begin
            n_fails++; $display("FAIL bp_timeout: drained %0d pixels expected 16", idx);
        end
        n_checks++;
        if (pb_rts_cb !== 1'b0) begin
            n_fails++; $display("FAIL bp_after: rts got %b expected 0", pb_rts_cb);
        end
    endtask

    task automatic test_enable_hold;
        logic [11:0] exp_v [8];
        exp_v = '{12'hF08, 12'hE19, 12'hD2A, 12'hC3B, 12'hB4C, 12'hA5D, 12'h96E, 12'h87F};
        cb_rtr_pb = 1'b1;
        drive_set(32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF);
        tick();
        idle();
        tick();
        tick();
        tick();
        enable = 1'b0;
        rb_data = 32'hDEADBEEF;
        rb_rts_pb = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({pb_rts_cb, pb_rtr_rb, pb_rtr_gb, pb_rtr_bb, pb_data} !== {4'b0000, exp_v[3]}) begin
                n_fails++; $display("FAIL en_low_c%0d: got rts=%b rtr=%b data=%h expected rts=0 rtr=000 data=%h",
                                    c, pb_rts_cb, {pb_rtr_rb, pb_rtr_gb, pb_rtr_bb}, pb_data, exp_v[3]);
            end
            tick();
        end
        enable = 1'b1;
        idle();
        #1;
        n_checks++;
        if (pb_rtr_rb !== 1'b1) begin
            n_fails++; $display("FAIL en_no_load: rtr_rb got %b expected 1", pb_rtr_rb);
        end
        for (int i = 3; i < 8; i++) begin
            n_checks++;
            if ({pb_rts_cb, pb_data} !== {1'b1, exp_v[i]}) begin
                n_fails++; $display("FAIL en_resume_pix%0d: got rts=%b data=%h expected rts=1 data=%h",
                                    i, pb_rts_cb, pb_data, exp_v[i]);
            end
            tick();
        end
        n_checks++;
        if (pb_rts_cb !== 1'b0) begin
            n_fails++; $display("FAIL en_after: rts got %b expected 0", pb_rts_cb);
        end
    endtask

    task automatic test_reset_mid;
        cb_rtr_pb = 1'b1;
        drive_set(r_set[0], g_set[0], b_set[0]);
        tick();
        idle();
        rb_data = r_set[1];
        rb_rts_pb = 1'b1;
        tick();
        idle();
        tick();
        n_checks++;
        if ({pb_rts_cb, pb_data} !== {1'b1, exp_pix(r_set[0], g_set[0], b_set[0], 2)}) begin
            n_fails++; $display("FAIL rmid_pre: got rts=%b data=%h expected rts=1 data=%h",
                                pb_rts_cb, pb_data, exp_pix(r_set[0], g_set[0], b_set[0], 2));
        end
        rst_ = 1'b0;
        #1;
        n_checks++;
        if ({pb_rts_cb, pb_data, pb_rtr_rb, pb_rtr_gb, pb_rtr_bb} !== {1'b0, 12'h000, 3'b111}) begin
            n_fails++; $display("FAIL rmid_async: got rts=%b data=%h rtr=%b expected rts=0 data=000 rtr=111",
                                pb_rts_cb, pb_data, {pb_rtr_rb, pb_rtr_gb, pb_rtr_bb});
        end
        tick();
        rst_ = 1'b1;
        drive_set(r_set[1], g_set[1], b_set[1]);
        tick();
        idle();
        #1;
        n_checks++;
        if ({pb_rts_cb, pb_data} !== {1'b1, exp_pix(r_set[1], g_set[1], b_set[1], 0)}) begin
            n_fails++; $display("FAIL rmid_reload: got rts=%b data=%h expected rts=1 data=%h",
                                pb_rts_cb, pb_data, exp_pix(r_set[1], g_set[1], b_set[1], 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_set();
        test_staggered();
        test_ping_pong();
        test_back_pressure();
        test_enable_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
